// File: rtl/spi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_resp_pkg
// Purpose  : Shared types and constants for the SPI register responder.
//            Holds the frame FSM state type, register-file geometry and
//            the bit positions used to decode the command byte.
// Revision : 1.0  initial release
// ============================================================================
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    localparam int REG_COUNT     = 32;
    localparam int ADDR_W        = 5;
    localparam int BIT_CNT_W     = 3;

    // Command byte layout: [7:3] register address, [1] write flag.
    localparam int CMD_ADDR_MSB  = 7;
    localparam int CMD_ADDR_LSB  = 3;
    localparam int CMD_WRITE_BIT = 1;

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Two-flop synchroniser for one asynchronous input, followed by
//            an edge detector working on the synchronised value.
// Ports    : clk, rst_n      - system clock, async active-low reset
//            i_async         - asynchronous input
//            o_sync          - synchronised level
//            o_rise, o_fall  - one-clk pulses on synchronised edges
// Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise =  r_sync & ~r_prev;
    assign o_fall = ~r_sync &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_responder
// Purpose  : SPI mode-0 responder in front of a 32 x 8 flip-flop register
//            file. First byte of a frame is a command (address + R/W), the
//            following bytes stream data with auto-incrementing address.
// Ports    : Clk, Reset_n          - system clock, async active-low reset
//            SS_n, SCLK, MOSI      - SPI inputs (asynchronous to Clk)
//            MISO, MISO_oe         - SPI output and its output enable
//            status_in             - byte returned during the command byte
//            wr_valid/addr/data    - one-clk notification per written byte
//            rd_addr, rd_data      - combinational local register read
// Revision : 1.0  initial release
// ============================================================================
module spi_reg_responder
    import spi_resp_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [7:0]        status_in,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic w_ss_sync,   w_ss_rise,   w_ss_fall;
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;

    // SS_n resets to the "selected" level so that releasing reset while the
    // initiator already holds SS_n low produces no falling edge; the FSM then
    // waits for a genuinely new frame.
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_ss (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_async (SS_n),
        .o_sync  (w_ss_sync),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_async (SCLK),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_async (MOSI),
        .o_sync  (w_mosi_sync),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    logic w_unused_edges;
    assign w_unused_edges = &{1'b0, w_sclk_sync, w_mosi_rise, w_mosi_fall};

    spi_state_t           r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]           r_shift_in;
    logic [7:0]           r_shift_out;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_is_write;
    logic                 r_byte_done;
    logic                 r_miso;
    logic                 r_miso_oe;
    logic                 r_wr_valid;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [7:0]           r_wr_data;
    logic [7:0]           r_regs [REG_COUNT];

    logic [ADDR_W-1:0]    w_cmd_addr;
    assign w_cmd_addr = cmd_addr(r_shift_in);

    // r_byte_done marks the Clk after the 8th rising SCLK edge; the byte is
    // only acted on if SS_n has not risen in that same Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_byte_done <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_valid <= 1'b0;
            r_miso_oe  <= ~w_ss_sync;

            if (w_ss_rise) begin
                r_state     <= IDLE;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
                r_miso      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_ss_fall) begin
                            r_state     <= CMD;
                            r_bit_cnt   <= '0;
                            r_byte_done <= 1'b0;
                            r_shift_out <= status_in;
                            r_miso      <= status_in[7];
                        end
                    end

                    CMD, DATA: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= {r_shift_in[6:0], w_mosi_sync};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end
                        r_byte_done <= w_sclk_rise && (r_bit_cnt == 3'd7);

                        // After k rising edges the next bit out is 7-k; when
                        // the counter has wrapped this selects the MSB of the
                        // byte loaded at the boundary.
                        if (w_sclk_fall) begin
                            r_miso <= r_shift_out[3'd7 - r_bit_cnt];
                        end

                        if (r_byte_done) begin
                            if (r_state == CMD) begin
                                r_state    <= DATA;
                                r_is_write <= r_shift_in[CMD_WRITE_BIT];
                                if (r_shift_in[CMD_WRITE_BIT]) begin
                                    r_addr      <= w_cmd_addr;
                                    r_shift_out <= 8'h00;
                                end else begin
                                    r_addr      <= w_cmd_addr + 5'd1;
                                    r_shift_out <= r_regs[w_cmd_addr];
                                end
                            end else if (r_is_write) begin
                                r_regs[r_addr] <= r_shift_in;
                                r_wr_valid     <= 1'b1;
                                r_wr_addr      <= r_addr;
                                r_wr_data      <= r_shift_in;
                                r_addr         <= r_addr + 5'd1;
                                r_shift_out    <= 8'h00;
                            end else begin
                                r_shift_out <= r_regs[r_addr];
                                r_addr      <= r_addr + 5'd1;
                            end
                        end
                    end

                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign MISO     = r_miso;
    assign MISO_oe  = r_miso_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_data  = r_regs[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_responder
// Purpose  : Self-checking bench for spi_reg_responder. Drives SPI frames at
//            SCLK = Clk/8 with random SS_n setup and keeps an array model of
//            the register file plus a queue of expected write notifications.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_reg_responder;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       MISO_oe;
    logic [7:0] status_in = 8'h00;
    logic       wr_valid;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;

    spi_reg_responder dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .MISO_oe   (MISO_oe),
        .status_in (status_in),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #10 Clk = ~Clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          wr_count    = 0;
    logic [7:0]  m_regs [32];
    logic [12:0] exp_q [$];
    logic [12:0] exp_e;
    logic        chk_oe = 1'b0;
    logic [7:0]  tx [8];
    logic [7:0]  rx [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write notifications and output enable are checked every cycle.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (wr_valid) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wr_unexpected: got addr %0d data 0x%02h, expected no pulse", wr_addr, wr_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_event", {19'd0, wr_addr, wr_data}, {19'd0, exp_e});
                end
            end
            if (chk_oe) check("miso_oe_active", {31'd0, MISO_oe}, 32'd1);
        end
    end

    task automatic check_regs();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), {24'd0, rd_data}, {24'd0, m_regs[i]});
        end
    endtask

    // One SPI frame: tx[] holds the bytes, nbits may end mid-byte.
    task automatic frame(input logic [7:0] status, input int nbits);
        logic [4:0] a;
        logic       wr;
        logic [4:0] idx;
        logic [7:0] exp_b;
        int         k;
        int         b;
        a  = tx[0][7:3];
        wr = tx[0][1];
        status_in = status;
        SS_n = 1'b0;
        MOSI = tx[0][7];
        #($urandom_range(0, 150));
        for (int i = 0; i < nbits; i++) begin
            k   = i / 8;
            b   = 7 - (i % 8);
            idx = a + 5'(k - 1);
            if (k == 0)  exp_b = status;
            else if (wr) exp_b = 8'h00;
            else         exp_b = m_regs[idx];
            #80;
            if (i == 0) chk_oe = 1'b1;
            rx[k][b] = MISO;
            check($sformatf("miso_byte%0d_bit%0d", k, b), {31'd0, MISO}, {31'd0, exp_b[b]});
            if (b == 0 && k >= 1 && wr) begin
                m_regs[idx] = tx[k];
                exp_q.push_back({idx, tx[k]});
            end
            SCLK = 1'b1;
            #80;
            SCLK = 1'b0;
            if (i + 1 < nbits) MOSI = tx[(i + 1) / 8][7 - ((i + 1) % 8)];
        end
        #100;
        chk_oe = 1'b0;
        SS_n = 1'b1;
        #240;
        check("miso_oe_idle", {31'd0, MISO_oe}, 32'd0);
        check("wr_pending", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    int c0;
    int nb;
    int nbits;

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;

        // Reset state
        #35;
        check("rst_miso",     {31'd0, MISO},     32'd0);
        check("rst_miso_oe",  {31'd0, MISO_oe},  32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_addr",  {27'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {24'd0, wr_data},  32'd0);
        #3 Reset_n = 1'b1;
        #200;
        check_regs();

        // Write 0x5C to reg 7 with status 0xA5
        tx[0] = 8'h3A; tx[1] = 8'h5C;
        c0 = wr_count;
        frame(8'hA5, 16);
        check("t1_status_byte", {24'd0, rx[0]}, 32'hA5);
        check("t1_data_byte",   {24'd0, rx[1]}, 32'h00);
        check("t1_wr_pulses",   wr_count - c0,  32'd1);
        rd_addr = 5'd7; #1;
        check("t1_reg7", {24'd0, rd_data}, 32'h5C);
        check_regs();

        // Read reg 7
        tx[0] = 8'h38; tx[1] = 8'h00;
        c0 = wr_count;
        frame(8'h3C, 16);
        check("t2_status_byte", {24'd0, rx[0]}, 32'h3C);
        check("t2_read_byte",   {24'd0, rx[1]}, 32'h5C);
        check("t2_wr_pulses",   wr_count - c0,  32'd0);

        // Write burst wrapping 31 -> 0
        tx[0] = 8'hFA; tx[1] = 8'h11; tx[2] = 8'h22;
        c0 = wr_count;
        frame(8'h00, 24);
        check("t3_wr_pulses", wr_count - c0, 32'd2);
        rd_addr = 5'd31; #1;
        check("t3_reg31", {24'd0, rd_data}, 32'h11);
        rd_addr = 5'd0; #1;
        check("t3_reg0",  {24'd0, rd_data}, 32'h22);

        // Aborted after 5 data bits, then a normal frame
        tx[0] = 8'h1A; tx[1] = 8'hFF;
        c0 = wr_count;
        frame(8'h00, 13);
        check("t4_wr_pulses", wr_count - c0, 32'd0);
        check_regs();
        tx[0] = 8'h1A; tx[1] = 8'h77;
        frame(8'h00, 16);
        rd_addr = 5'd3; #1;
        check("t4_reg3", {24'd0, rd_data}, 32'h77);

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < 8; j++) tx[j] = 8'($urandom);
            nb    = $urandom_range(1, 5);
            nbits = nb * 8;
            if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, 7);
            frame(8'($urandom), nbits);
            check_regs();
        end

        // Reset asserted mid-byte, released while SS_n is still low
        tx[0] = 8'h52;
        SS_n = 1'b0;
        MOSI = tx[0][7];
        #90;
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1; #80; SCLK = 1'b0;
            MOSI = tx[0][6 - i];
            #80;
        end
        #37 Reset_n = 1'b0;
        #1;
        check("arst_miso",     {31'd0, MISO},     32'd0);
        check("arst_miso_oe",  {31'd0, MISO_oe},  32'd0);
        check("arst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("arst_wr_addr",  {27'd0, wr_addr},  32'd0);
        check("arst_wr_data",  {24'd0, wr_data},  32'd0);
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        exp_q.delete();
        check_regs();
        #55 Reset_n = 1'b1;
        c0 = wr_count;
        MOSI = 1'b1;
        #100;
        for (int i = 0; i < 20; i++) begin
            SCLK = 1'b1; #80; SCLK = 1'b0; #80;
        end
        SS_n = 1'b1;
        #240;
        check("t5_no_frame_wr", wr_count - c0, 32'd0);
        check_regs();

        tx[0] = 8'h22; tx[1] = 8'h9D;
        frame(8'h81, 16);
        check("t5_status_byte", {24'd0, rx[0]}, 32'h81);
        rd_addr = 5'd4; #1;
        check("t5_reg4", {24'd0, rd_data}, 32'h9D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have port Clk, input, 1, 50 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port SS_n, input, 1, SPI chip select from the initiator, asynchronous, active-low.
REQ-004 SHALL have port SCLK, input, 1, SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous, frequency at most Clk/8.
REQ-005 SHALL have port MOSI, input, 1, initiator data, MSB first.
REQ-006 SHALL have port MISO, output, 1, responder data, MSB first.
REQ-007 SHALL have port MISO_oe, output, 1, high while SS_n (synchronised) is low; the top level tristates MISO when it is low.
REQ-008 SHALL have port status_in, input, 8, status byte returned during the command byte.
REQ-009 SHALL have port wr_valid, output, 1, one-Clk pulse per completed SPI write byte.
REQ-010 SHALL have port wr_addr, output, 5, register address of that write.
REQ-011 SHALL have port wr_data, output, 8, data byte of that write.
REQ-012 SHALL have port rd_addr, input, 5, local read address.
REQ-013 SHALL have port rd_data, output, 8, combinational local read of reg[rd_addr].

Function
REQ-014 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronisers and detect SCLK rising and falling edges from the synchronised value.
REQ-015 SHALL run FSM IDLE -> CMD on SS_n falling; CMD -> DATA after 8 bits; DATA repeats per byte; any state -> IDLE on SS_n rising.
REQ-016 SHALL, on entry to CMD, load the shift-out register with status_in, captured on the Clk edge that detects SS_n low.
REQ-017 SHALL sample MOSI on each SCLK rising edge and update MISO on each SCLK falling edge; MISO SHALL hold the MSB of the loaded byte before the first rising edge.
REQ-018 SHALL decode the command byte as: bits[7:3] = address, bit[1] = 1 for write and 0 for read; bits 2 and 0 are ignored.
REQ-019 SHALL, in a read transaction, load reg[addr] into the shifter at each byte boundary and then increment addr modulo 32 (31 wraps to 0).
REQ-020 SHALL, in a write transaction, write reg[addr] and pulse wr_valid 1 Clk after the 8th rising SCLK of each data byte, then increment addr modulo 32.
REQ-021 SHALL make MISO shift out 0x00 during write data bytes.
REQ-022 SHALL discard a partial byte on SS_n rising: no register write and no wr_valid pulse.
REQ-023 SHALL treat an SS_n rising edge and a byte completion in the same Clk as abort; the byte is not written.
REQ-024 SHALL use an internal bit counter of 3 bits that wraps 7 -> 0 at each byte boundary.

Reset
REQ-025 SHALL, on Reset_n low, clear all 32 registers to 0x00, set the FSM to IDLE, clear counters, and drive MISO=0, MISO_oe=0, wr_valid=0, wr_addr=0 and wr_data=0.
REQ-026 SHALL, when reset is released while SS_n is low, stay in IDLE until a fresh SS_n falling edge.

Structure
REQ-027 SHALL place state enum spi_state_t {IDLE, CMD, DATA}, REG_COUNT=32, ADDR_W=5 and the command bit positions in package spi_resp_pkg.
REQ-028 SHALL implement the synchroniser and edge detector as sub-module spi_sync_edge, instanced once per input.
REQ-029 SHALL keep the register file as flip-flops, not inferred RAM.

Verification
REQ-030 SHALL verify: with status_in=0xA5, command 0x3A then data 0x5C -> MISO returns 0xA5 then 0x00; reg[7]=0x5C; one wr_valid pulse with wr_addr=7 and wr_data=0x5C.
REQ-031 SHALL verify: with reg[7]=0x5C preloaded, command 0x38 -> MISO returns 0x5C in the data byte; no wr_valid pulse.
REQ-032 SHALL verify: write to addr 31 with data 0x11 then 0x22 -> reg[31]=0x11 and reg[0]=0x22.
REQ-033 SHALL verify: SS_n raised after 5 data bits -> no wr_valid and registers unchanged; the next transaction decodes normally.
REQ-034 SHALL verify: Reset_n asserted mid-byte -> all outputs reach reset values within 1 Clk (asynchronously); rd_data=0x00 for all addresses.
REQ-035 SHALL verify: SCLK=Clk/8 with randomised SS_n setup time -> every byte is bit-exact against the reference model.
